// File: rtl/mac_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mac_chain_ctrl
// Description : Sequencer for a linear GF MAC PE chain: clear, stream MAC
//               beats, then shift accumulators out of the chain tail.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_chain_ctrl #(
  parameter int GF_BIT      = 4,
  parameter int OP_CODE_LEN = 4,
  parameter int N_PE        = 16,
  parameter int LEN_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [LEN_W-1:0]       cmd_len,
  input  logic                   src_valid,
  output logic                   src_ready,
  input  logic [GF_BIT-1:0]      tail_dataB,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [GF_BIT-1:0]      res_data,
  output logic [LEN_W-1:0]       res_idx,
  output logic                   res_last,
  output logic [OP_CODE_LEN-1:0] op_out,
  output logic [1:0]             gauss_op_out,
  output logic                   start_out,
  output logic                   busy,
  output logic                   done
);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_CLEAR  = 3'd1;
  localparam logic [2:0] c_ST_MAC    = 3'd2;
  localparam logic [2:0] c_ST_UNLOAD = 3'd3;
  localparam logic [2:0] c_ST_DONE   = 3'd4;

  localparam logic [OP_CODE_LEN-1:0] c_OP_HOLD  = OP_CODE_LEN'(0);
  localparam logic [OP_CODE_LEN-1:0] c_OP_CLEAR = OP_CODE_LEN'(3);
  localparam logic [OP_CODE_LEN-1:0] c_OP_MAC   = OP_CODE_LEN'(7);
  localparam logic [OP_CODE_LEN-1:0] c_OP_SHIFT = OP_CODE_LEN'(4);

  localparam logic [LEN_W-1:0] c_IDX_LAST = LEN_W'(N_PE - 1);

  logic [2:0]       r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_beat;
  logic [LEN_W-1:0] r_idx;
  logic [LEN_W-1:0] w_beat_next;

  assign w_beat_next = r_beat + LEN_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
      r_len   <= '0;
      r_beat  <= '0;
      r_idx   <= c_IDX_LAST;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (cmd_valid) begin
            r_len   <= cmd_len;
            r_beat  <= '0;
            r_idx   <= c_IDX_LAST;
            r_state <= c_ST_CLEAR;
          end
        end
        c_ST_CLEAR: begin
          r_state <= (r_len != '0) ? c_ST_MAC : c_ST_UNLOAD;
        end
        c_ST_MAC: begin
          if (src_valid) begin
            r_beat <= w_beat_next;
            if (w_beat_next == r_len) r_state <= c_ST_UNLOAD;
          end
        end
        c_ST_UNLOAD: begin
          // The tail element is always produced first, so the index walks down.
          if (res_ready) begin
            if (r_idx == '0) begin
              r_idx   <= c_IDX_LAST;
              r_state <= c_ST_DONE;
            end else begin
              r_idx <= r_idx - LEN_W'(1);
            end
          end
        end
        c_ST_DONE: r_state <= c_ST_IDLE;
        default:   r_state <= c_ST_IDLE;
      endcase
    end
  end

  always_comb begin
    op_out = c_OP_HOLD;
    case (r_state)
      c_ST_CLEAR:  op_out = c_OP_CLEAR;
      c_ST_MAC:    op_out = src_valid ? c_OP_MAC : c_OP_HOLD;
      c_ST_UNLOAD: op_out = res_ready ? c_OP_SHIFT : c_OP_HOLD;
      default:     op_out = c_OP_HOLD;
    endcase
  end

  assign cmd_ready    = (r_state == c_ST_IDLE);
  assign busy         = (r_state != c_ST_IDLE);
  assign done         = (r_state == c_ST_DONE);
  assign src_ready    = (r_state == c_ST_MAC);
  assign res_valid    = (r_state == c_ST_UNLOAD);
  assign res_last     = res_valid && (r_idx == '0);
  assign res_idx      = r_idx;
  assign res_data     = tail_dataB;
  assign gauss_op_out = 2'b00;
  assign start_out    = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_mac_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_chain_ctrl
// Description : Directed plus randomized bench for mac_chain_ctrl with a
//               behavioural PE chain and a per-cycle expected timeline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_chain_ctrl;

  localparam int GF  = 4;
  localparam int OPW = 4;
  localparam int N   = 4;
  localparam int LW  = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid, cmd_ready;
  logic [LW-1:0]  cmd_len;
  logic           src_valid, src_ready;
  logic [GF-1:0]  tail_dataB;
  logic           res_valid, res_ready;
  logic [GF-1:0]  res_data;
  logic [LW-1:0]  res_idx;
  logic           res_last;
  logic [OPW-1:0] op_out;
  logic [1:0]     gauss_op_out;
  logic           start_out, busy, done;

  mac_chain_ctrl #(.GF_BIT(GF), .OP_CODE_LEN(OPW), .N_PE(N), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .src_valid(src_valid), .src_ready(src_ready), .tail_dataB(tail_dataB),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_idx(res_idx), .res_last(res_last), .op_out(op_out),
    .gauss_op_out(gauss_op_out), .start_out(start_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic       sv, rr, srdy, rvld, rlast, dn;
    logic [7:0] idx;
    logic [3:0] rdat;
  } exp_t;

  int         n_checks = 0;
  int         n_err    = 0;
  logic [3:0] acc    [N];
  logic [3:0] key    [N];
  logic [3:0] beat_a [16][N];
  int         bi = 0;
  bit         sv_pat[$];
  bit         rr_pat[$];
  bit         rand_stall = 0;
  exp_t       tl[$];
  logic [3:0] op_cap;

  // GF(2^4) multiply, reduction polynomial x^4 + x + 1.
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] x;
    p = 4'h0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = x[3] ? ((x << 1) ^ 4'h3) : (x << 1);
    end
    return p;
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Behavioural PE chain: reacts to the op bus seen at each rising edge.
  task automatic apply_chain(input logic [3:0] op);
    case (op)
      4'd3: begin
        for (int i = 0; i < N; i++) acc[i] = 4'h0;
        bi = 0;
      end
      4'd7: begin
        if (bi < 16) for (int i = 0; i < N; i++) acc[i] = acc[i] ^ gf_mul(key[i], beat_a[bi][i]);
        bi++;
      end
      4'd4: begin
        for (int i = N - 1; i > 0; i--) acc[i] = acc[i-1];
        acc[0] = 4'h0;
      end
      default: ;
    endcase
  endtask

  task automatic drive(input logic cv, input logic [7:0] cl, input logic sv, input logic rr);
    cmd_valid  = cv;
    cmd_len    = cl;
    src_valid  = sv;
    res_ready  = rr;
    tail_dataB = acc[N-1];
  endtask

  task automatic tick();
    op_cap = op_out;
    @(posedge clk);
    apply_chain(op_cap);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      drive(1'b0, 8'($urandom), rb(), rb());
      @(negedge clk);
      chk("idle_cmd_ready", cmd_ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_op", op_out, 0);
      chk("idle_done", done, 0);
      chk("idle_src_ready", src_ready, 0);
      chk("idle_res_valid", res_valid, 0);
      tick();
    end
  endtask

  task automatic run_cmd(input int len, input bit hold, input int abort_at);
    exp_t       e;
    logic [3:0] res [N];
    int         ones, k, stalls, done_at, n_done;
    for (int i = 0; i < N; i++) begin
      res[i] = 4'h0;
      for (int b = 0; b < len; b++) res[i] = res[i] ^ gf_mul(key[i], beat_a[b][i]);
    end
    tl.delete();
    stalls = 0;
    e = '{default: 0}; e.op = 4'd3; e.sv = rb(); e.rr = rb();
    tl.push_back(e);
    ones = 0;
    while (ones < len) begin
      e = '{default: 0};
      e.srdy = 1'b1;
      e.sv = (sv_pat.size() > 0) ? sv_pat.pop_front()
           : (rand_stall ? ($urandom_range(0, 2) != 0) : 1'b1);
      e.rr = rb();
      e.op = e.sv ? 4'd7 : 4'd0;
      if (e.sv) ones++; else stalls++;
      tl.push_back(e);
    end
    k = 0;
    while (k < N) begin
      e = '{default: 0};
      e.rvld = 1'b1;
      e.rr = (rr_pat.size() > 0) ? rr_pat.pop_front()
           : (rand_stall ? ($urandom_range(0, 2) != 0) : 1'b1);
      e.sv = rb();
      e.op = e.rr ? 4'd4 : 4'd0;
      e.idx = 8'(N - 1 - k);
      e.rlast = (k == N - 1);
      e.rdat = res[N-1-k];
      if (e.rr) k++; else stalls++;
      tl.push_back(e);
    end
    e = '{default: 0}; e.dn = 1'b1; e.sv = rb(); e.rr = rb();
    tl.push_back(e);

    drive(1'b1, 8'(len), rb(), rb());
    @(negedge clk);
    chk("accept_cmd_ready", cmd_ready, 1);
    chk("accept_busy", busy, 0);
    chk("accept_op", op_out, 0);
    tick();

    done_at = -1;
    n_done  = 0;
    for (int j = 0; j < tl.size(); j++) begin
      drive(hold, 8'($urandom), tl[j].sv, tl[j].rr);
      if (j == abort_at) begin
        #2;
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_op", op_out, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_res_idx", res_idx, N - 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b0, 8'($urandom), rb(), rb());
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        tick();
        return;
      end
      @(negedge clk);
      chk("op_out", op_out, tl[j].op);
      chk("src_ready", src_ready, tl[j].srdy);
      chk("res_valid", res_valid, tl[j].rvld);
      chk("res_last", res_last, tl[j].rlast);
      chk("done", done, tl[j].dn);
      chk("busy", busy, 1);
      chk("cmd_ready", cmd_ready, 0);
      if (tl[j].rvld) begin
        chk("res_idx", res_idx, tl[j].idx);
        chk("res_data", res_data, tl[j].rdat);
      end
      if (done === 1'b1) begin
        n_done++;
        if (done_at < 0) done_at = j + 1;
      end
      tick();
    end
    chk("done_latency", done_at, 2 + len + N + stalls);
    chk("done_count", n_done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) acc[i] = 4'h0;
    rst = 1'b1;
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_op", op_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_src_ready", src_ready, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_res_idx", res_idx, N - 1);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_res_last", res_last, 0);
    chk("gauss_op_out", gauss_op_out, 0);
    chk("start_out", start_out, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle_cycles(2);

    // Key 1 everywhere, dataA beats 1,2,4: every accumulator ends at 7.
    for (int i = 0; i < N; i++) begin
      key[i] = 4'h1;
      beat_a[0][i] = 4'h1;
      beat_a[1][i] = 4'h2;
      beat_a[2][i] = 4'h4;
    end
    rand_stall = 0;
    run_cmd(3, 1'b0, -1);
    idle_cycles(1);

    run_cmd(0, 1'b0, -1);
    idle_cycles(1);

    sv_pat = '{1, 0, 0, 1, 1};
    run_cmd(3, 1'b0, -1);
    idle_cycles(1);

    rr_pat = '{1, 0, 0, 0};
    run_cmd(3, 1'b0, -1);
    idle_cycles(1);

    run_cmd(3, 1'b0, 3);
    run_cmd(3, 1'b0, -1);
    idle_cycles(1);

    run_cmd(3, 1'b1, -1);
    run_cmd(2, 1'b0, -1);
    idle_cycles(1);

    rand_stall = 1;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < N; i++) begin
        key[i] = 4'($urandom);
        for (int b = 0; b < 16; b++) beat_a[b][i] = 4'($urandom);
      end
      run_cmd($urandom_range(0, 12), (r % 3) == 0, -1);
      idle_cycles($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
